// File: rtl/mem_responder.sv
// mem_responder: single-outstanding memory responder for one initiator with
// three request sources (instruction fetch, data read, data write).
// Requests are arbitrated in IDLE (write > read > fetch), latched, and served
// either by the SRAM (fixed WAIT+1 strobe cycles) or by the I/O port (held
// until io_ack, or until an IO_TMO-cycle timeout that returns 16'hFFFF and
// pulses bus_err). Each access ends in a one-cycle DONE state that pulses the
// done strobe of the requesting source.
//
// Ports:
//   clk, reset               clock; synchronous active-low reset
//   pc, ifetch               fetch word address and level request
//   addr, rstrobe, wmask     data word address, read lanes, write byte enables
//   wdata, io_access         write data; steers a data request to the I/O port
//   idone/rdone/wdone        one-cycle completion pulses
//   idata, rdata             fetched word / lane-formatted read data (held)
//   bus_err                  one-cycle pulse with the done of a timed-out I/O
//   sram_*                   SRAM strobes, address, data; sram_q read data
//   io_*                     I/O strobes, address, byte enables, data, ack
module mem_responder #(
    parameter int RV     = 16,
    parameter int VA     = 16,
    parameter int WAIT   = 1,
    parameter int IO_TMO = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [VA-2:0] pc,
    input  logic          ifetch,
    input  logic [VA-2:0] addr,
    input  logic [1:0]    rstrobe,
    input  logic [1:0]    wmask,
    input  logic [RV-1:0] wdata,
    input  logic          io_access,
    output logic          idone,
    output logic          rdone,
    output logic          wdone,
    output logic [RV-1:0] idata,
    output logic [RV-1:0] rdata,
    output logic          bus_err,
    output logic          sram_ce,
    output logic          sram_we,
    output logic [1:0]    sram_be,
    output logic [VA-2:0] sram_a,
    output logic [RV-1:0] sram_d,
    input  logic [RV-1:0] sram_q,
    output logic          io_rd,
    output logic          io_wr,
    output logic [VA-2:0] io_a,
    output logic [1:0]    io_be,
    output logic [RV-1:0] io_d,
    input  logic [RV-1:0] io_q,
    input  logic          io_ack
);

    localparam int HALF = RV / 2;

    typedef enum logic [1:0] {IDLE, MEM, IO, DONE} state_t;
    typedef enum logic [1:0] {SRC_F, SRC_R, SRC_W} src_t;

    state_t        state, next;
    src_t          src, gnt_src;
    logic          grant;
    logic [VA-2:0] lat_addr;
    logic [1:0]    lat_be;
    logic [RV-1:0] lat_wdata;
    logic [3:0]    cnt;
    logic          err;
    logic [RV-1:0] word;

    // Next state, grant and state-decoded outputs. Strobes and done pulses
    // depend only on the registered state, so a reset edge silences them
    // immediately.
    always_comb begin
        next    = state;
        grant   = 1'b0;
        gnt_src = SRC_F;
        sram_ce = 1'b0;
        sram_we = 1'b0;
        io_rd   = 1'b0;
        io_wr   = 1'b0;
        idone   = 1'b0;
        rdone   = 1'b0;
        wdone   = 1'b0;
        bus_err = 1'b0;
        case (state)
            IDLE: begin
                if (|wmask) begin
                    grant   = 1'b1;
                    gnt_src = SRC_W;
                end else if (|rstrobe) begin
                    grant   = 1'b1;
                    gnt_src = SRC_R;
                end else if (ifetch) begin
                    grant   = 1'b1;
                    gnt_src = SRC_F;
                end
                // fetches never go to I/O
                if (grant)
                    next = (gnt_src != SRC_F && io_access) ? IO : MEM;
            end
            MEM: begin
                sram_ce = 1'b1;
                sram_we = (src == SRC_W);
                if (cnt == 4'(WAIT))
                    next = DONE;
            end
            IO: begin
                io_rd = (src != SRC_W);
                io_wr = (src == SRC_W);
                if (io_ack || cnt == 4'(IO_TMO - 1))
                    next = DONE;
            end
            DONE: begin
                idone   = (src == SRC_F);
                rdone   = (src == SRC_R);
                wdone   = (src == SRC_W);
                bus_err = err;
                next    = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    assign sram_be = (src == SRC_W) ? lat_be : 2'b11;
    assign sram_a  = lat_addr;
    assign sram_d  = lat_wdata;
    assign io_a    = lat_addr;
    assign io_be   = lat_be;
    assign io_d    = lat_wdata;

    // Word returned by the access that is completing this cycle.
    always_comb begin
        word = sram_q;
        if (state == IO)
            word = io_ack ? io_q : {RV{1'b1}};
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            src       <= SRC_F;
            lat_addr  <= '0;
            lat_be    <= '0;
            lat_wdata <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            rdata     <= '0;
            idata     <= '0;
        end else begin
            state <= next;
            if (grant) begin
                src       <= gnt_src;
                lat_addr  <= (gnt_src == SRC_F) ? pc : addr;
                lat_be    <= (gnt_src == SRC_W) ? wmask :
                             (gnt_src == SRC_R) ? rstrobe : 2'b11;
                lat_wdata <= wdata;
                cnt       <= '0;
                err       <= 1'b0;
            end else if (state == MEM || state == IO) begin
                cnt <= cnt + 4'd1;
            end
            // Capture on the edge into DONE so the data is valid during the pulse
            // and held afterwards.
            if ((state == MEM || state == IO) && next == DONE) begin
                err <= (state == IO) && !io_ack;
                if (src == SRC_F)
                    idata <= word;
                if (src == SRC_R) begin
                    case (lat_be)
                        2'b01:   rdata <= {{HALF{1'b0}}, word[HALF-1:0]};
                        2'b10:   rdata <= {{HALF{1'b0}}, word[RV-1:HALF]};
                        default: rdata <= word;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (default parameters:
// WAIT=1, IO_TMO=15). Inputs change and outputs are sampled 1 ns after
// each rising edge.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] pc, addr, sram_a, io_a;
    logic        ifetch, io_access, io_ack;
    logic [1:0]  rstrobe, wmask, sram_be, io_be;
    logic [15:0] wdata, idata, rdata, sram_d, sram_q, io_d, io_q;
    logic        idone, rdone, wdone, bus_err, sram_ce, sram_we, io_rd, io_wr;

    int nchk = 0;
    int nerr = 0;

    mem_responder dut (
        .clk(clk), .reset(reset), .pc(pc), .ifetch(ifetch), .addr(addr),
        .rstrobe(rstrobe), .wmask(wmask), .wdata(wdata), .io_access(io_access),
        .idone(idone), .rdone(rdone), .wdone(wdone), .idata(idata), .rdata(rdata),
        .bus_err(bus_err), .sram_ce(sram_ce), .sram_we(sram_we), .sram_be(sram_be),
        .sram_a(sram_a), .sram_d(sram_d), .sram_q(sram_q), .io_rd(io_rd),
        .io_wr(io_wr), .io_a(io_a), .io_be(io_be), .io_d(io_d), .io_q(io_q),
        .io_ack(io_ack)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; pc = '0; addr = '0; ifetch = 0; io_access = 0; io_ack = 0;
        rstrobe = '0; wmask = '0; wdata = '0; sram_q = '0; io_q = '0;
        tick(); tick();
        nchk++;
        if ({sram_ce, sram_we, io_rd, io_wr, idone, rdone, wdone, bus_err} !== 8'h00) begin
            nerr++; $display("FAIL reset_strobes: got %b want 00000000",
                {sram_ce, sram_we, io_rd, io_wr, idone, rdone, wdone, bus_err});
        end
        nchk++;
        if (rdata !== 16'h0 || idata !== 16'h0) begin
            nerr++; $display("FAIL reset_data: rdata=%h idata=%h want 0000/0000", rdata, idata);
        end
        reset = 1'b1;
        tick();
    endtask

    task automatic test_fetch();
        ifetch = 1; pc = 15'h0010; sram_q = 16'h1234;
        tick();
        nchk++;
        if (sram_ce !== 1 || sram_a !== 15'h0010 || sram_we !== 0 || sram_be !== 2'b11) begin
            nerr++; $display("FAIL fetch_mem1: ce=%b a=%h we=%b be=%b want 1 0010 0 11",
                sram_ce, sram_a, sram_we, sram_be);
        end
        tick();
        nchk++;
        if (sram_ce !== 1 || idone !== 0) begin
            nerr++; $display("FAIL fetch_mem2: ce=%b idone=%b want 1 0", sram_ce, idone);
        end
        tick();
        nchk++;
        if (idone !== 1 || idata !== 16'h1234 || sram_ce !== 0 || rdone !== 0 || wdone !== 0) begin
            nerr++; $display("FAIL fetch_done: idone=%b idata=%h ce=%b want 1 1234 0",
                idone, idata, sram_ce);
        end
        ifetch = 0; sram_q = 16'h0000;
        tick();
        nchk++;
        if (idone !== 0 || idata !== 16'h1234 || sram_ce !== 0) begin
            nerr++; $display("FAIL fetch_hold: idone=%b idata=%h ce=%b want 0 1234 0",
                idone, idata, sram_ce);
        end
    endtask

    task automatic test_priority();
        wmask = 2'b10; wdata = 16'hAB00; addr = 15'h0020; ifetch = 1; pc = 15'h0030;
        sram_q = 16'h7E57;
        tick();
        nchk++;
        if (sram_we !== 1 || sram_be !== 2'b10 || sram_a !== 15'h0020 || sram_d !== 16'hAB00) begin
            nerr++; $display("FAIL prio_write: we=%b be=%b a=%h d=%h want 1 10 0020 ab00",
                sram_we, sram_be, sram_a, sram_d);
        end
        tick(); tick();
        nchk++;
        if (wdone !== 1 || idone !== 0) begin
            nerr++; $display("FAIL prio_wdone: wdone=%b idone=%b want 1 0", wdone, idone);
        end
        wmask = 2'b00;
        tick();
        nchk++;
        if (sram_ce !== 0 || wdone !== 0 || idone !== 0) begin
            nerr++; $display("FAIL prio_idle: ce=%b wdone=%b idone=%b want 0 0 0",
                sram_ce, wdone, idone);
        end
        tick();
        nchk++;
        if (sram_ce !== 1 || sram_we !== 0 || sram_a !== 15'h0030 || sram_be !== 2'b11) begin
            nerr++; $display("FAIL prio_fetch: ce=%b we=%b a=%h be=%b want 1 0 0030 11",
                sram_ce, sram_we, sram_a, sram_be);
        end
        tick(); tick();
        nchk++;
        if (idone !== 1 || idata !== 16'h7E57) begin
            nerr++; $display("FAIL prio_idone: idone=%b idata=%h want 1 7e57", idone, idata);
        end
        ifetch = 0;
        tick();
    endtask

    task automatic test_rw_collision();
        wmask = 2'b01; wdata = 16'h0042; rstrobe = 2'b11; addr = 15'h0005; sram_q = 16'h9911;
        tick();
        nchk++;
        if (sram_we !== 1 || sram_be !== 2'b01) begin
            nerr++; $display("FAIL rw_write_first: we=%b be=%b want 1 01", sram_we, sram_be);
        end
        tick(); tick();
        nchk++;
        if (wdone !== 1 || rdone !== 0) begin
            nerr++; $display("FAIL rw_wdone: wdone=%b rdone=%b want 1 0", wdone, rdone);
        end
        wmask = 2'b00;
        tick(); tick();
        nchk++;
        if (sram_ce !== 1 || sram_we !== 0 || sram_be !== 2'b11) begin
            nerr++; $display("FAIL rw_read_next: ce=%b we=%b be=%b want 1 0 11",
                sram_ce, sram_we, sram_be);
        end
        tick(); tick();
        nchk++;
        if (rdone !== 1 || rdata !== 16'h9911) begin
            nerr++; $display("FAIL rw_rdone: rdone=%b rdata=%h want 1 9911", rdone, rdata);
        end
        rstrobe = 2'b00;
        tick();
    endtask

    task automatic do_read(input logic [1:0] lanes, input logic [15:0] exp);
        rstrobe = lanes; addr = 15'h0044; sram_q = 16'hC3A5;
        tick(); tick(); tick();
        nchk++;
        if (rdone !== 1 || rdata !== exp) begin
            nerr++; $display("FAIL read_lane_%b: rdone=%b rdata=%h want 1 %h", lanes, rdone, rdata, exp);
        end
        rstrobe = 2'b00;
        tick();
        nchk++;
        if (rdone !== 0 || rdata !== exp) begin
            nerr++; $display("FAIL read_hold_%b: rdone=%b rdata=%h want 0 %h", lanes, rdone, rdata, exp);
        end
    endtask

    task automatic test_read_lanes();
        do_read(2'b10, 16'h00C3);
        do_read(2'b01, 16'h00A5);
        do_read(2'b11, 16'hC3A5);
    endtask

    task automatic test_io_read();
        int hi = 0;
        io_access = 1; rstrobe = 2'b11; addr = 15'h0040; io_q = 16'h5A5A; sram_q = 16'h1111;
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (io_rd === 1 && sram_ce === 0) hi++;
            if (i == 4) io_ack = 1;
        end
        tick();
        nchk++;
        if (hi != 4) begin
            nerr++; $display("FAIL io_rd_cycles: got %0d want 4", hi);
        end
        nchk++;
        if (rdone !== 1 || rdata !== 16'h5A5A || bus_err !== 0 || io_rd !== 0) begin
            nerr++; $display("FAIL io_read_done: rdone=%b rdata=%h err=%b rd=%b want 1 5a5a 0 0",
                rdone, rdata, bus_err, io_rd);
        end
        io_ack = 0; rstrobe = 2'b00; io_access = 0;
        tick();
    endtask

    task automatic test_io_timeout();
        int hi = 0;
        bit seen = 0;
        io_access = 1; wmask = 2'b11; wdata = 16'h1357; addr = 15'h0060;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (wdone === 1) seen = 1;
            else if (io_wr === 1) hi++;
        end
        nchk++;
        if (!seen) begin
            nerr++; $display("FAIL io_tmo_wdone: no wdone within 40 cycles");
        end
        nchk++;
        if (hi != 15) begin
            nerr++; $display("FAIL io_wr_cycles: got %0d want 15", hi);
        end
        nchk++;
        if (bus_err !== 1 || io_wr !== 0) begin
            nerr++; $display("FAIL io_tmo_err: bus_err=%b io_wr=%b want 1 0", bus_err, io_wr);
        end
        wmask = 2'b00; io_access = 0;
        tick();
        nchk++;
        if (bus_err !== 0 || wdone !== 0) begin
            nerr++; $display("FAIL io_tmo_pulse: bus_err=%b wdone=%b want 0 0", bus_err, wdone);
        end
    endtask

    task automatic test_reset_abort();
        rstrobe = 2'b11; addr = 15'h0050; sram_q = 16'h4321;
        tick();
        tick();
        nchk++;
        if (sram_ce !== 1) begin
            nerr++; $display("FAIL abort_mem2: ce=%b want 1", sram_ce);
        end
        reset = 0;
        tick();
        nchk++;
        if (sram_ce !== 0 || rdone !== 0 || io_rd !== 0) begin
            nerr++; $display("FAIL abort_ce: ce=%b rdone=%b want 0 0", sram_ce, rdone);
        end
        rstrobe = 2'b00;
        tick();
        reset = 1;
        nchk++;
        if (rdone !== 0 || rdata !== 16'h0 || idata !== 16'h0) begin
            nerr++; $display("FAIL abort_clear: rdone=%b rdata=%h idata=%h want 0 0000 0000",
                rdone, rdata, idata);
        end
        ifetch = 1; pc = 15'h0011; sram_q = 16'hBEEF;
        tick(); tick(); tick();
        nchk++;
        if (idone !== 1 || idata !== 16'hBEEF || rdone !== 0) begin
            nerr++; $display("FAIL abort_refetch: idone=%b idata=%h rdone=%b want 1 beef 0",
                idone, idata, rdone);
        end
        ifetch = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_priority();
        test_rw_collision();
        test_read_lanes();
        test_io_read();
        test_io_timeout();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RV, default 16, SHALL set the data word width; only 16 is supported.
REQ-002 Parameter VA, default 16, SHALL set the byte-address width; word addresses are VA-1 bits wide ([VA-1:1]).
REQ-003 Parameter WAIT, default 1, range 0-7, SHALL set the number of SRAM wait cycles per access.
REQ-004 Parameter IO_TMO, default 15, range 1-15, SHALL set the I/O timeout limit in cycles.
REQ-005 Ports SHALL be as follows:
  clk  in  1  clock, all state on rising edge
  reset  in  1  synchronous, active-low
  pc  in  VA-1  instruction word address
  ifetch  in  1  fetch request, level, held until idone
  addr  in  VA-1  data word address
  rstrobe  in  2  read request plus byte lanes: [1] high byte, [0] low byte
  wmask  in  2  write request plus byte enables
  wdata  in  RV  write data, lane aligned
  io_access  in  1  qualifies the data request as I/O
  idone / rdone / wdone  out  1 each  one-cycle completion pulses
  idata  out  RV  fetched instruction, valid while idone
  rdata  out  RV  read data, valid while rdone
  bus_err  out  1  one-cycle pulse on I/O timeout
  sram_ce, sram_we  out  1 each  SRAM strobes
  sram_be  out  2  SRAM byte enables
  sram_a  out  VA-1  SRAM word address
  sram_d  out  RV  SRAM write data
  sram_q  in  RV  SRAM read data
  io_rd, io_wr  out  1 each  I/O strobes, level
  io_a  out  VA-1  I/O address
  io_be  out  2  I/O byte enables
  io_d  out  RV  I/O write data
  io_q  in  RV  I/O read data
  io_ack  in  1  I/O completion

Function
REQ-006 The FSM SHALL have four states: IDLE, MEM, IO, DONE.
REQ-007 In IDLE, the grant SHALL be fixed priority: write (|wmask) > read (|rstrobe) > fetch (ifetch).
REQ-008 A fetch SHALL always go to MEM; io_access SHALL be ignored for fetches.
REQ-009 On grant, the block SHALL latch source, address (pc or addr), lanes and wdata into registers.
REQ-010 On grant, the next state SHALL be IO if io_access=1 for a data request, otherwise MEM.
REQ-011 MEM SHALL assert sram_ce for WAIT+1 cycles, driving sram_a/sram_be/sram_d from the latched registers.
REQ-012 In MEM, sram_we SHALL equal 1 for writes; sram_be SHALL be wmask for writes and 2'b11 for reads and fetches.
REQ-013 On the last MEM cycle, the block SHALL capture sram_q and go to DONE; grant-to-done latency SHALL be WAIT+2 cycles.
REQ-014 In IO, io_rd or io_wr SHALL be held until io_ack=1 is sampled; the block SHALL then capture io_q and go to DONE.
REQ-015 An IO-state counter SHALL count cycles; if io_ack is still 0 after IO_TMO cycles, the block SHALL go to DONE with captured data 16'hFFFF and bus_err pulsed in DONE.
REQ-016 DONE SHALL last exactly one cycle and pulse the done signal matching the source; the next state SHALL be IDLE.
REQ-017 Requests present in DONE SHALL NOT be granted; arbitration SHALL resume the following cycle, because the initiator drops its request on the done edge.
REQ-018 Read lane rule SHALL be: rstrobe 2'b11 -> rdata = word; 2'b01 -> {8'h00, word[7:0]}; 2'b10 -> {8'h00, word[15:8]}. The initiator sign-extends.
REQ-019 idata SHALL always be the full captured word.
REQ-020 rdata and idata SHALL hold their last value outside done pulses.
REQ-021 At most one done pulse SHALL occur per cycle, and only one access SHALL be outstanding at a time.
REQ-022 Outside their active states, sram_ce, sram_we, io_rd and io_wr SHALL be 0.
REQ-023 A write with wmask 2'b00 SHALL NOT be possible; a simultaneous read and write SHALL be served as the write, and the read SHALL be served next.

Reset
REQ-024 While reset=0 at a clock edge: state SHALL become IDLE; all done pulses, bus_err, sram_ce, sram_we, io_rd, io_wr SHALL be 0; rdata and idata SHALL be 0; counters SHALL be 0.
REQ-025 Reset asserted mid-access SHALL abort the access with no done pulse and no further SRAM or I/O strobes from the next edge.

Verification
REQ-026 WAIT=1, ifetch=1, pc=0x0010, sram_q=0x1234 -> sram_ce high for 2 cycles with sram_a=0x0010, idone pulses on cycle 3 with idata=0x1234.
REQ-027 In the same IDLE cycle: wmask=2'b10 with wdata=0xAB00 at addr 0x0020, plus ifetch -> write served first (sram_we=1, sram_be=2'b10); wdone; one idle cycle; then fetch; idone.
REQ-028 rstrobe=2'b10, sram_q=0xC3A5 -> rdone with rdata=0x00C3; rstrobe=2'b01 -> 0x00A5; rstrobe=2'b11 -> 0xC3A5.
REQ-029 io_access=1 read, io_ack returned after 4 cycles with io_q=0x5A5A -> io_rd high for 4 cycles, rdone with rdata=0x5A5A, bus_err=0.
REQ-030 IO_TMO=15, I/O write, io_ack never asserted -> io_wr high for 15 cycles, then wdone and bus_err pulse together.
REQ-031 reset=0 during the second MEM cycle of a read -> no rdone; sram_ce=0 next cycle; after release, a new fetch completes normally.
